// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount as timed dime/nickel eject pulses, dimes first, tracking hopper stock.
// Define CHANGE_TOTAL_EN to add the paid_total output (cents ejected for the current request).
`timescale 1ns/1ps
module change_dispenser #(
  parameter int N            = 6,
  parameter int CNT_W        = 8,
  parameter int NICKEL_INIT  = 8,
  parameter int DIME_INIT    = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [N-1:0]     req_amount,
  output logic             req_ready,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             busy,
  output logic             done,
  output logic             short_out,
  input  logic             refill_nickel,
  input  logic             refill_dime,
  output logic [CNT_W-1:0] nickel_stock,
  output logic [CNT_W-1:0] dime_stock
`ifdef CHANGE_TOTAL_EN
  ,
  output logic [N-1:0]     paid_total
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]    T_ONE      = TW'(1);
  localparam logic [N-1:0]     FIVE       = N'(5);
  localparam logic [N-1:0]     TEN        = N'(10);
  localparam logic [CNT_W-1:0] STOCK_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STOCK_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N-1:0]     remaining_q, remaining_d;
  logic             nickel_out_q, nickel_out_d;
  logic             dime_out_q, dime_out_d;
  logic             done_q, done_d;
  logic             short_out_q, short_out_d;
  logic [CNT_W-1:0] nickel_stock_q, nickel_stock_d;
  logic [CNT_W-1:0] dime_stock_q, dime_stock_d;
`ifdef CHANGE_TOTAL_EN
  logic [N-1:0]     paid_q, paid_d;
`endif

  logic in_select;
  logic pick_dime;
  logic pick_nickel;

  // Greedy coin choice; the guards also keep remaining from underflowing.
  assign in_select   = (state_q == S_SELECT);
  assign pick_dime   = in_select && (remaining_q >= TEN) && (dime_stock_q != '0);
  assign pick_nickel = in_select && !pick_dime && (remaining_q >= FIVE) && (nickel_stock_q != '0);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    remaining_d  = remaining_q;
    nickel_out_d = nickel_out_q;
    dime_out_d   = dime_out_q;
    done_d       = 1'b0;
    short_out_d  = 1'b0;
`ifdef CHANGE_TOTAL_EN
    paid_d       = paid_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          state_d     = S_SELECT;
`ifdef CHANGE_TOTAL_EN
          paid_d      = '0;
`endif
        end
      end
      S_SELECT: begin
        if (pick_dime) begin
          remaining_d = remaining_q - TEN;
          dime_out_d  = 1'b1;
          timer_d     = PULSE_LAST;
          state_d     = S_PULSE;
`ifdef CHANGE_TOTAL_EN
          paid_d      = paid_q + TEN;
`endif
        end else if (pick_nickel) begin
          remaining_d  = remaining_q - FIVE;
          nickel_out_d = 1'b1;
          timer_d      = PULSE_LAST;
          state_d      = S_PULSE;
`ifdef CHANGE_TOTAL_EN
          paid_d       = paid_q + FIVE;
`endif
        end else begin
          // A sub-5 remainder is dropped quietly; 5 or more left means a hopper ran dry.
          done_d      = 1'b1;
          short_out_d = (remaining_q >= FIVE);
          state_d     = S_DONE;
        end
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          nickel_out_d = 1'b0;
          dime_out_d   = 1'b0;
          timer_d      = GAP_LAST;
          state_d      = S_GAP;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A refill landing on the same edge as a payout from that hopper cancels out.
  always_comb begin
    nickel_stock_d = nickel_stock_q;
    if (refill_nickel && !pick_nickel) begin
      if (nickel_stock_q != STOCK_MAX) nickel_stock_d = nickel_stock_q + STOCK_ONE;
    end else if (pick_nickel && !refill_nickel) begin
      nickel_stock_d = nickel_stock_q - STOCK_ONE;
    end

    dime_stock_d = dime_stock_q;
    if (refill_dime && !pick_dime) begin
      if (dime_stock_q != STOCK_MAX) dime_stock_d = dime_stock_q + STOCK_ONE;
    end else if (pick_dime && !refill_dime) begin
      dime_stock_d = dime_stock_q - STOCK_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      remaining_q    <= '0;
      nickel_out_q   <= 1'b0;
      dime_out_q     <= 1'b0;
      done_q         <= 1'b0;
      short_out_q    <= 1'b0;
      nickel_stock_q <= CNT_W'(NICKEL_INIT);
      dime_stock_q   <= CNT_W'(DIME_INIT);
`ifdef CHANGE_TOTAL_EN
      paid_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      remaining_q    <= remaining_d;
      nickel_out_q   <= nickel_out_d;
      dime_out_q     <= dime_out_d;
      done_q         <= done_d;
      short_out_q    <= short_out_d;
      nickel_stock_q <= nickel_stock_d;
      dime_stock_q   <= dime_stock_d;
`ifdef CHANGE_TOTAL_EN
      paid_q         <= paid_d;
`endif
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign nickel_out   = nickel_out_q;
  assign dime_out     = dime_out_q;
  assign done         = done_q;
  assign short_out    = short_out_q;
  assign nickel_stock = nickel_stock_q;
  assign dime_stock   = dime_stock_q;
`ifdef CHANGE_TOTAL_EN
  assign paid_total   = paid_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy payout model, timing of every coin and done strobe.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int N    = 6;
  localparam int CW   = 8;
  localparam int NI   = 8;
  localparam int DI   = 8;
  localparam int P    = 4;
  localparam int G    = 4;
  localparam int STEP = P + G + 1;
  localparam int SMAX = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [N-1:0]  req_amount;
  logic          req_ready;
  logic          nickel_out;
  logic          dime_out;
  logic          busy;
  logic          done;
  logic          short_out;
  logic          refill_nickel;
  logic          refill_dime;
  logic [CW-1:0] nickel_stock;
  logic [CW-1:0] dime_stock;
`ifdef CHANGE_TOTAL_EN
  logic [N-1:0]  paid_total;
`endif

  change_dispenser #(
    .N(N), .CNT_W(CW), .NICKEL_INIT(NI), .DIME_INIT(DI),
    .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_amount(req_amount),
    .req_ready(req_ready),
    .nickel_out(nickel_out),
    .dime_out(dime_out),
    .busy(busy),
    .done(done),
    .short_out(short_out),
    .refill_nickel(refill_nickel),
    .refill_dime(refill_dime),
    .nickel_stock(nickel_stock),
    .dime_stock(dime_stock)
`ifdef CHANGE_TOTAL_EN
    ,
    .paid_total(paid_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          e;     // accept edge number
    int          n;     // coins expected
    logic [15:0] seq;   // 1 = dime, 0 = nickel, in eject order
    bit          sh;
    int          ns;
    int          ds;
    int          paid;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mn = NI;
  int   md = DI;
  int   k = 0;
  int   run = 0;
  logic pd = 1'b0;
  logic pn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat_inc(input int v);
    return (v < SMAX) ? v + 1 : SMAX;
  endfunction

  // Reference: dimes while 10+ is owed and dimes remain, else nickels while 5+ is owed.
  function automatic exp_t predict(input int amt, input int e);
    exp_t r;
    int   rem;
    r.e = e; r.n = 0; r.seq = '0; r.sh = 1'b0; r.paid = 0;
    rem = amt;
    while (rem >= 5) begin
      if (rem >= 10 && md > 0) begin
        r.seq[r.n] = 1'b1; md--; rem -= 10; r.paid += 10; r.n++;
      end else if (mn > 0) begin
        r.seq[r.n] = 1'b0; mn--; rem -= 5; r.paid += 5; r.n++;
      end else begin
        r.sh = 1'b1;
        break;
      end
    end
    r.ns = mn;
    r.ds = md;
    return r;
  endfunction

  // Monitor: checks each coin against the head of the scoreboard and pops on done.
  always @(negedge clk) begin
    if (reset) begin
      k = 0; run = 0; pd = 1'b0; pn = 1'b0;
    end else begin
      if ((dime_out && !pd) || (nickel_out && !pn)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL coin_unexpected dime=%0b nickel=%0b with no request pending", dime_out, nickel_out);
        end else if (k >= sb[0].n || (dime_out && nickel_out) || dime_out != sb[0].seq[k] ||
                     (cyc - sb[0].e + 1) != 2 + k * STEP) begin
          errors++;
          $display("FAIL coin k=%0d got dime=%0b nickel=%0b at cycle %0d, expected dime=%0b at cycle %0d of %0d coins",
                   k, dime_out, nickel_out, cyc - sb[0].e + 1,
                   (k < sb[0].n) ? sb[0].seq[k] : 1'b0, 2 + k * STEP, sb[0].n);
        end
        k++;
      end
      if ((pd && !dime_out) || (pn && !nickel_out)) begin
        checks++;
        if (run != P) begin
          errors++;
          $display("FAIL pulse_len got %0d cycles, expected %0d", run, P);
        end
      end
      run = (dime_out || nickel_out) ? run + 1 : 0;
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected short=%0b with no request pending", short_out);
        end else begin
          bit bad;
          int pgot;
          cur  = sb.pop_front();
          pgot = -1;
          bad  = (k != cur.n) || (short_out != cur.sh) || (int'(nickel_stock) != cur.ns) ||
                 (int'(dime_stock) != cur.ds) || ((cyc - cur.e + 1) != 2 + cur.n * STEP);
`ifdef CHANGE_TOTAL_EN
          pgot = int'(paid_total);
          if (pgot != cur.paid) bad = 1'b1;
`endif
          if (bad) begin
            errors++;
            $display("FAIL done got coins=%0d short=%0b nstock=%0d dstock=%0d cycle=%0d paid=%0d; expected coins=%0d short=%0b nstock=%0d dstock=%0d cycle=%0d paid=%0d",
                     k, short_out, nickel_stock, dime_stock, cyc - cur.e + 1, pgot,
                     cur.n, cur.sh, cur.ns, cur.ds, 2 + cur.n * STEP, cur.paid);
          end
        end
        k = 0;
      end else begin
        checks++;
        if (short_out) begin
          errors++;
          $display("FAIL short_outside_done got short_out=1, expected 0");
        end
      end
      pd = dime_out;
      pn = nickel_out;
    end
  end

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout req_ready=%0b after %0d cycles, expected 1", req_ready, t);
      finish_run();
    end
  endtask

  task automatic send(input int amt, input bit hold, input bit rsel);
    exp_t r;
    int   t;
    wait_ready();
    req_valid  = 1'b1;
    req_amount = N'(amt);
    r = predict(amt, cyc + 1);
    if (rsel) begin
      mn   = sat_inc(mn);
      r.ns = mn;
    end
    sb.push_back(r);
    @(negedge clk);
    if (rsel) refill_nickel = 1'b1;
    if (!hold) req_valid = 1'b0;
    if (rsel) begin
      @(negedge clk);
      refill_nickel = 1'b0;
    end
    if (hold) begin
      t = 0;
      while (!req_ready && t < 2000) begin
        req_amount = N'($urandom_range(0, 63));
        @(negedge clk);
        t++;
      end
      req_valid = 1'b0;
    end
  endtask

  task automatic refill(input int nn, input int nd);
    int len;
    wait_ready();
    len = (nn > nd) ? nn : nd;
    for (int i = 0; i < len; i++) begin
      refill_nickel = (i < nn);
      refill_dime   = (i < nd);
      if (i < nn) mn = sat_inc(mn);
      if (i < nd) md = sat_inc(md);
      @(negedge clk);
    end
    refill_nickel = 1'b0;
    refill_dime   = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (nickel_out || dime_out || done || short_out || busy || !req_ready ||
        int'(nickel_stock) != NI || int'(dime_stock) != DI) begin
      errors++;
      $display("FAIL %s got n=%0b d=%0b done=%0b short=%0b busy=%0b ready=%0b nstock=%0d dstock=%0d; expected 0 0 0 0 0 1 %0d %0d",
               name, nickel_out, dime_out, done, short_out, busy, req_ready, nickel_stock, dime_stock, NI, DI);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d requests outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    int t;
    reset = 1'b1; req_valid = 1'b0; req_amount = '0;
    refill_nickel = 1'b0; refill_dime = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_state");
    reset = 1'b0;

    send(25, 1'b0, 1'b0);   // dime, dime, nickel
    send(0, 1'b0, 1'b0);
    send(7, 1'b0, 1'b0);
    send(63, 1'b0, 1'b0);   // empties the dime hopper
    send(30, 1'b0, 1'b0);   // empties the nickel hopper in nickels
    refill(2, 1);
    send(30, 1'b0, 1'b0);   // dime, nickel, nickel, then short
    drain();
    refill(3, 0);
    send(5, 1'b0, 1'b1);    // refill coinciding with the nickel payout
    send(35, 1'b1, 1'b0);   // valid held through busy with a changing amount

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) refill($urandom_range(0, 4), $urandom_range(0, 4));
      send($urandom_range(0, 63), ($urandom_range(0, 3) == 0), 1'b0);
    end
    drain();

    refill(300, 20);
    checks++;
    if (int'(nickel_stock) != mn || int'(dime_stock) != md) begin
      errors++;
      $display("FAIL refill_saturate got nstock=%0d dstock=%0d, expected %0d %0d", nickel_stock, dime_stock, mn, md);
    end

    send(25, 1'b0, 1'b0);
    t = 0;
    while (!(dime_out || nickel_out) && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(dime_out || nickel_out)) begin
      errors++;
      $display("FAIL pulse_timeout got no eject pulse within %0d cycles, expected one", t);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("reset_mid_pulse");
    sb.delete();
    mn = NI;
    md = DI;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 4; i++) send($urandom_range(0, 63), 1'b0, 1'b0);
    drain();
    finish_run();
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out a change amount as timed coin pulses to the nickel and dime hoppers.
- Sits downstream of the vending controller, which computes the change. Replaces single-cycle nickel/dime strobes with a proper request handshake and a coin sequencer.
- Tracks hopper stock, uses the greedy dime-first algorithm, and reports shortfall when stock runs out.

Parameters:
- N, 6, width of change amount in cents
- CNT_W, 8, width of each hopper stock counter
- NICKEL_INIT, 8, nickel stock loaded at reset
- DIME_INIT, 8, dime stock loaded at reset
- PULSE_CYCLES, 4, cycles a coin-eject output is held high (>=1)
- GAP_CYCLES, 4, cycles all eject outputs are held low between coins (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  change request present
- req_amount  input  N  change in cents, sampled on handshake
- req_ready  output  1  high only in IDLE
- nickel_out  output  1  nickel eject pulse
- dime_out  output  1  dime eject pulse
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion strobe
- short_out  output  1  stock exhausted before full payout; valid with done
- refill_nickel  input  1  add one nickel to stock this cycle
- refill_dime  input  1  add one dime to stock this cycle
- nickel_stock  output  CNT_W  current nickel count
- dime_stock  output  CNT_W  current dime count

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - nickel_out = dime_out = done = short_out = busy = 0
  - req_ready = 1
  - nickel_stock = NICKEL_INIT, dime_stock = DIME_INIT
  - remaining = 0
- Reset mid-operation: the in-flight pulse drops immediately, the request is abandoned, and no done is issued.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch req_amount into remaining, clear the short flag, go to SELECT.
- SELECT (exactly 1 cycle, outputs low). Rules in priority order:
  - remaining >= 10 and dime_stock > 0: coin = dime.
  - else remaining >= 5 and nickel_stock > 0: coin = nickel.
  - else remaining >= 5: set short, go to DONE.
  - else (remaining < 5): go to DONE. A sub-5 remainder is dropped silently and is not short.
  - Once a coin is chosen, on the same edge: decrement that coin's stock, subtract 10 or 5 from remaining, go to PULSE.
- PULSE:
  - The selected output is high for exactly PULSE_CYCLES cycles; the other output stays low.
  - Then go to GAP.
- GAP:
  - Both outputs low for GAP_CYCLES cycles, then go to SELECT.
- DONE (1 cycle):
  - done = 1 and short_out = short flag; then go to IDLE.
  - short_out is 0 outside DONE.
- Greedy fallback: when dime_stock = 0, a remaining of 10 or more is paid in nickels.
- Refill:
  - Each refill input adds 1 to its stock, saturating at 2^CNT_W - 1.
  - Refill in the same cycle as a decrement of the same hopper: net change 0.
  - Refill is accepted in every state.
- Mutual exclusion: nickel_out and dime_out are never high together.
- Arithmetic: remaining is N bits; subtraction never underflows because of the guard conditions.
- req_valid outside IDLE is ignored. The requester must hold req_valid until it sees req_ready.

Optional Feature:
- Macro: CHANGE_TOTAL_EN.
- When defined:
  - Adds output paid_total (N bits): cents actually ejected for the current request.
  - Cleared on handshake, incremented by 5 or 10 in SELECT, stable and valid while done = 1.
  - Holds its value in IDLE; reset value 0.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
All scenarios use default parameters unless stated; the accept edge is cycle 0.
- Amount 25, full stock:
  - dime_out high cycles 2-5 and 11-14; nickel_out high cycles 20-23.
  - done in cycle 29, short_out = 0.
  - dime_stock 8->6, nickel_stock 8->7, paid_total = 25.
- Amount 0:
  - No pulses; done in cycle 2, short_out = 0.
- Amount 7:
  - One nickel pulse, done with short_out = 0, paid_total = 5.
- Amount 30 with DIME_INIT = 1, NICKEL_INIT = 2:
  - Coins: dime, nickel, nickel; then done with short_out = 1.
  - Both stocks 0, paid_total = 20.
- Edge cases:
  - refill_nickel asserted in the same cycle as a nickel SELECT: nickel_stock unchanged.
  - 300 refill pulses from 8: saturates at 255.
  - req_valid held during busy: no second request accepted until IDLE.
- Reset asserted mid-PULSE:
  - All outputs 0 immediately, stocks back to INIT, req_ready = 1.
  - No done issued.
